cmd_issuer: RTL and testbench

CMD_ISSUER -- requirements
Module: cmd_issuer

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cmd_fifo.sv | 36 +++
 rtl/cmd_issuer.sv | 109 ++++++++++
 tb/tb_cmd_issuer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state, command encoding and response flag layout for cmd_issuer.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam int CMD_W = 7;
  localparam logic [CMD_W-1:0] CMD_NOP = 7'h00;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_ERROR = 1;
  localparam int FLAG_TIMEOUT = 2;
  function automatic logic [2:0] mk_flags(input logic t, input logic e, input logic z);
    logic [2:0] f;
    f = '0;
    f[FLAG_TIMEOUT] = t;
    f[FLAG_ERROR] = e;
    f[FLAG_ZERO] = z;
    return f;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: power-of-two command queue; wrapping pointers carry an extra bit to tell full from empty.
module cmd_fifo #(
  parameter int W = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign head_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(do_push);
      rd_q <= rd_q + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/cmd_issuer.sv
// cmd_issuer: queues host commands and issues them one at a time to a CPU, holding each result for the host.
// Optional issue/wait watchdog enabled by defining CMD_ISSUER_TIMEOUT_EN.
module cmd_issuer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_valid,
  input  logic [CMD_W-1:0]   host_cmd,
  output logic               host_ready,
  output logic [CMD_W-1:0]   cmd_in,
  input  logic               cpu_rdy,
  input  logic [2*WIDTH-1:0] res_data,
  input  logic               res_zero,
  input  logic               res_error,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic [2:0]         rsp_flags,
  output logic               busy
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_params
    $error("cmd_issuer: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
  end
  state_e state_q, state_d;
  logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [2:0] rsp_flags_q, rsp_flags_d;
  logic [CMD_W-1:0] head;
  logic full, empty, pop, tmo;
  cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(host_valid),
    .pop_i(pop),
    .data_i(host_cmd),
    .head_o(head),
    .full_o(full),
    .empty_o(empty)
  );
`ifdef CMD_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmr_q, tmr_d;
  assign tmo = tmr_q == TW'(TIMEOUT - 1);
  // restarts from zero on every state entry so ISSUE and WAIT each get a full budget
  always_comb tmr_d = (state_d == state_q && (state_q == ISSUE || state_q == WAIT)) ? tmr_q + 1'b1 : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmr_q <= '0;
    else tmr_q <= tmr_d;
  end
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rsp_data_q <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end
  always_comb begin
    state_d = state_q;
    rsp_data_d = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty && cpu_rdy) state_d = ISSUE;
      ISSUE: begin
        if (!cpu_rdy) begin
          state_d = WAIT;
          pop = 1'b1;
        end else if (tmo) begin
          state_d = RESP;
          pop = 1'b1;
          rsp_data_d = '0;
          rsp_flags_d = mk_flags(1'b1, 1'b0, 1'b0);
        end
      end
      WAIT: begin
        if (cpu_rdy) begin
          state_d = RESP;
          rsp_data_d = res_data;
          rsp_flags_d = mk_flags(1'b0, res_error, res_zero);
        end else if (tmo) begin
          state_d = RESP;
          rsp_data_d = '0;
          rsp_flags_d = mk_flags(1'b1, 1'b0, 1'b0);
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    host_ready = !full;
    cmd_in = (state_q == ISSUE) ? head : CMD_NOP;
    rsp_valid = state_q == RESP;
    rsp_data = rsp_data_q;
    rsp_flags = rsp_flags_q;
    busy = state_q != IDLE;
  end
endmodule

// File: tb/tb_cmd_issuer.sv
// tb_cmd_issuer: directed checks of queueing, issue handshake, response hold and reset for cmd_issuer.
module tb_cmd_issuer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic host_valid = 1'b0;
  logic [6:0] host_cmd = '0;
  logic host_ready;
  logic [6:0] cmd_in;
  logic cpu_rdy = 1'b0;
  logic [15:0] res_data = '0;
  logic res_zero = 1'b0;
  logic res_error = 1'b0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [2:0] rsp_flags;
  logic busy;
  int checks = 0;
  int failures = 0;
  cmd_issuer #(.WIDTH(8), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk),
    .reset(reset),
    .host_valid(host_valid),
    .host_cmd(host_cmd),
    .host_ready(host_ready),
    .cmd_in(cmd_in),
    .cpu_rdy(cpu_rdy),
    .res_data(res_data),
    .res_zero(res_zero),
    .res_error(res_error),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_flags(rsp_flags),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic push(input logic [6:0] c);
    host_valid = 1'b1;
    host_cmd = c;
    tick();
    host_valid = 1'b0;
  endtask
  task automatic wait_issue(input string tag, input logic [6:0] exp);
    for (int i = 0; i < 20 && cmd_in == 7'h00; i++) tick();
    check(tag, 32'(cmd_in), 32'(exp));
  endtask
  task automatic run_cmd(input string tag, input logic [6:0] exp, input logic [15:0] res,
                         input logic z, input logic e);
    cpu_rdy = 1'b1;
    wait_issue({tag, "_issue"}, exp);
    cpu_rdy = 1'b0;
    tick();
    check({tag, "_wait_nop"}, 32'(cmd_in), 32'h0);
    res_data = res;
    res_zero = z;
    res_error = e;
    cpu_rdy = 1'b1;
    tick();
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'(res));
    check({tag, "_rsp_flags"}, 32'(rsp_flags), 32'({1'b0, e, z}));
    res_data = ~res;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, 32'(rsp_valid), 32'h0);
  endtask
  initial begin
    tick();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cmd", 32'(cmd_in), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'h0);
    reset = 1'b0;
    cpu_rdy = 1'b1;
    tick();
    check("rdy_after_rst", 32'(host_ready), 32'h1);
    // basic command with cpu_rdy low for two cycles
    push(7'h15);
    check("no_bypass_cmd", 32'(cmd_in), 32'h0);
    check("no_bypass_busy", 32'(busy), 32'h0);
    tick();
    check("t1_issue", 32'(cmd_in), 32'h15);
    check("t1_busy", 32'(busy), 32'h1);
    cpu_rdy = 1'b0;
    tick();
    check("t1_wait_nop", 32'(cmd_in), 32'h0);
    tick();
    check("t1_wait_norsp", 32'(rsp_valid), 32'h0);
    res_data = 16'h00A5;
    cpu_rdy = 1'b1;
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_data", 32'(rsp_data), 32'h00A5);
    check("t1_rsp_flags", 32'(rsp_flags), 32'h0);
    res_data = 16'h5A5A;
    tick();
    check("t1_rsp_stable", 32'(rsp_data), 32'h00A5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t1_done_valid", 32'(rsp_valid), 32'h0);
    check("t1_done_busy", 32'(busy), 32'h0);
    // fill the FIFO while the CPU is stalled, then drain in order
    cpu_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) push(7'(k));
    check("full_ready", 32'(host_ready), 32'h0);
    push(7'h05);
    check("full_still", 32'(host_ready), 32'h0);
    check("full_idle", 32'(busy), 32'h0);
    run_cmd("q1", 7'h01, 16'h0101, 1'b0, 1'b0);
    check("q1_ready", 32'(host_ready), 32'h1);
    run_cmd("q2", 7'h02, 16'h0202, 1'b1, 1'b0);
    run_cmd("q3", 7'h03, 16'h0303, 1'b0, 1'b1);
    run_cmd("q4", 7'h04, 16'h0404, 1'b1, 1'b1);
    repeat (3) tick();
    check("drop5_busy", 32'(busy), 32'h0);
    check("drop5_cmd", 32'(cmd_in), 32'h0);
    // push on the same cycle the head is popped
    cpu_rdy = 1'b0;
    push(7'h31);
    push(7'h32);
    cpu_rdy = 1'b1;
    wait_issue("pp_issue", 7'h31);
    cpu_rdy = 1'b0;
    host_valid = 1'b1;
    host_cmd = 7'h33;
    tick();
    host_valid = 1'b0;
    check("pp_wait_nop", 32'(cmd_in), 32'h0);
    res_data = 16'h3131;
    cpu_rdy = 1'b1;
    tick();
    check("pp_rsp_data", 32'(rsp_data), 32'h3131);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    run_cmd("pp2", 7'h32, 16'h3232, 1'b0, 1'b0);
    run_cmd("pp3", 7'h33, 16'h3333, 1'b0, 1'b0);
    repeat (3) tick();
    check("pp_empty", 32'(busy), 32'h0);
    // host stalls the response; nothing new issues meanwhile
    cpu_rdy = 1'b0;
    push(7'h21);
    push(7'h22);
    cpu_rdy = 1'b1;
    wait_issue("hold_issue", 7'h21);
    cpu_rdy = 1'b0;
    tick();
    res_data = 16'h1234;
    cpu_rdy = 1'b1;
    tick();
    res_data = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(rsp_valid), 32'h1);
      check("hold_data", 32'(rsp_data), 32'h1234);
      check("hold_no_issue", 32'(cmd_in), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    run_cmd("flags", 7'h22, 16'h8000, 1'b1, 1'b1);
`ifdef CMD_ISSUER_TIMEOUT_EN
    cpu_rdy = 1'b0;
    push(7'h51);
    push(7'h52);
    cpu_rdy = 1'b1;
    wait_issue("tmo_issue", 7'h51);
    repeat (63) tick();
    check("tmo_pre", 32'(cmd_in), 32'h51);
    tick();
    check("tmo_valid", 32'(rsp_valid), 32'h1);
    check("tmo_flags", 32'(rsp_flags), 32'h4);
    check("tmo_data", 32'(rsp_data), 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    run_cmd("tmo_next", 7'h52, 16'h5252, 1'b0, 1'b0);
`endif
    // reset while a command is in flight with two more queued
    cpu_rdy = 1'b0;
    push(7'h41);
    push(7'h42);
    push(7'h43);
    cpu_rdy = 1'b1;
    wait_issue("rst_issue", 7'h41);
    cpu_rdy = 1'b0;
    tick();
    check("rst_in_wait", 32'(busy), 32'h1);
    reset = 1'b1;
    cpu_rdy = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_cmd", 32'(cmd_in), 32'h0);
    check("midrst_valid", 32'(rsp_valid), 32'h0);
    check("midrst_data", 32'(rsp_data), 32'h0);
    check("midrst_ready", 32'(host_ready), 32'h1);
    reset = 1'b0;
    repeat (4) tick();
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_cmd", 32'(cmd_in), 32'h0);
    check("post_rst_valid", 32'(rsp_valid), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
